// File: rtl/vga_pkg.sv
`default_nettype none
// ============================================================================
// Module   : vga_pkg
// Purpose  : Shared constants and state encoding for the rectangle-fill engine
// Revision : 1.0 - initial release
// ============================================================================

package vga_pkg;

  localparam int unsigned FB_ADDR_W = 15;

  localparam logic [7:0] XMAX_DEFAULT = 8'd159;
  localparam logic [6:0] YMAX_DEFAULT = 7'd119;

  // Register offsets from the base address
  localparam logic [7:0] FILL_X0   = 8'd0;
  localparam logic [7:0] FILL_Y0   = 8'd1;
  localparam logic [7:0] FILL_X1   = 8'd2;
  localparam logic [7:0] FILL_Y1   = 8'd3;
  localparam logic [7:0] FILL_CTRL = 8'd4;

  localparam logic [2:0] CTRL_COLOUR = 3'd0;
  localparam logic [2:0] CTRL_START  = 3'd1;
  localparam logic [2:0] CTRL_IRQCLR = 3'd2;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SETUP = 2'd1,
    FILL  = 2'd2,
    DONE  = 2'd3
  } fill_state_e;

endpackage

`default_nettype wire

// File: rtl/vga_fill_regs.sv
`default_nettype none
// ============================================================================
// Module   : vga_fill_regs
// Purpose  : Fill engine bus register bank, registered read driver and
//            START / IRQ_CLR pulse decode
// Revision : 1.0 - initial release
// ============================================================================

module vga_fill_regs
  import vga_pkg::*;
#(
  parameter logic [7:0] BASE_ADDR = 8'hC0
) (
  input  logic       clk_i,
  input  logic       rst_i,
  inout  wire  [7:0] bus_data_io,
  input  logic [7:0] bus_addr_i,
  input  logic       bus_we_i,
  input  logic       busy_i,
  input  logic       done_irq_i,
  output logic [7:0] x0_o,
  output logic [6:0] y0_o,
  output logic [7:0] x1_o,
  output logic [6:0] y1_o,
  output logic       colour_o,
  output logic       start_o,
  output logic       irq_clr_o
);

  logic [7:0] x0_q;
  logic [6:0] y0_q;
  logic [7:0] x1_q;
  logic [6:0] y1_q;
  logic       colour_q;
  logic [7:0] rd_data_q;
  logic [7:0] rd_data_d;
  logic       rd_oe_q;

  logic [7:0] w_off;
  logic [7:0] w_wdata;
  logic       w_hit;
  logic       w_wr;
  logic       w_rd;
  logic       w_cfg_wr;

  // Unsigned subtraction folds the lower-bound test into the range check
  assign w_off    = bus_addr_i - BASE_ADDR;
  assign w_hit    = (w_off <= FILL_CTRL);
  assign w_wr     = w_hit & bus_we_i;
  assign w_rd     = w_hit & ~bus_we_i;
  assign w_wdata  = bus_data_io;
  assign w_cfg_wr = w_wr & ~busy_i;

  assign start_o   = w_wr && (w_off == FILL_CTRL) && w_wdata[CTRL_START];
  assign irq_clr_o = w_wr && (w_off == FILL_CTRL) && w_wdata[CTRL_IRQCLR];

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      x0_q     <= 8'd0;
      y0_q     <= 7'd0;
      x1_q     <= 8'd0;
      y1_q     <= 7'd0;
      colour_q <= 1'b0;
    end else if (w_cfg_wr) begin
      case (w_off)
        FILL_X0:   x0_q     <= w_wdata;
        FILL_Y0:   y0_q     <= w_wdata[6:0];
        FILL_X1:   x1_q     <= w_wdata;
        FILL_Y1:   y1_q     <= w_wdata[6:0];
        FILL_CTRL: colour_q <= w_wdata[CTRL_COLOUR];
        default:   ;
      endcase
    end
  end

  always_comb begin
    rd_data_d = 8'h00;
    case (w_off)
      FILL_X0:   rd_data_d = x0_q;
      FILL_Y0:   rd_data_d = {1'b0, y0_q};
      FILL_X1:   rd_data_d = x1_q;
      FILL_Y1:   rd_data_d = {1'b0, y1_q};
      FILL_CTRL: rd_data_d = {busy_i, done_irq_i, 5'b0_0000, colour_q};
      default:   rd_data_d = 8'h00;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      rd_data_q <= 8'h00;
      rd_oe_q   <= 1'b0;
    end else begin
      rd_oe_q <= w_rd;
      if (w_rd) begin
        rd_data_q <= rd_data_d;
      end
    end
  end

  assign bus_data_io = rd_oe_q ? rd_data_q : 8'hzz;

  assign x0_o     = x0_q;
  assign y0_o     = y0_q;
  assign x1_o     = x1_q;
  assign y1_o     = y1_q;
  assign colour_o = colour_q;

endmodule

`default_nettype wire

// File: rtl/vga_fill_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : vga_fill_ctrl
// Purpose  : Rectangle-fill sequencer and frame buffer port A arbiter.
//            Define VGA_FILL_CLIP_EN to clamp the rectangle to the screen.
// Revision : 1.0 - initial release
// ============================================================================

module vga_fill_ctrl
  import vga_pkg::*;
#(
  parameter logic [7:0] BASE_ADDR = 8'hC0,
  parameter logic [7:0] X_MAX     = XMAX_DEFAULT,
  parameter logic [6:0] Y_MAX     = YMAX_DEFAULT
) (
  input  logic                 CLK,
  input  logic                 RESET,
  inout  wire  [7:0]           BUS_DATA,
  input  logic [7:0]           BUS_ADDR,
  input  logic                 BUS_WE,
  input  logic [FB_ADDR_W-1:0] CPU_PIX_ADDR,
  input  logic                 CPU_PIX_DATA,
  input  logic                 CPU_PIX_WE,
  output logic [FB_ADDR_W-1:0] FB_ADDR,
  output logic                 FB_DATA,
  output logic                 FB_WE,
  output logic                 BUSY,
  output logic                 DONE_IRQ
);

  fill_state_e state_q, state_d;

  logic [7:0]           xl_q, xl_d, xh_q, xh_d, cx_q, cx_d;
  logic [6:0]           yl_q, yl_d, yh_q, yh_d, cy_q, cy_d;
  logic                 done_irq_q, done_irq_d;
  logic [FB_ADDR_W-1:0] fb_addr_q, fb_addr_d;
  logic                 fb_data_q, fb_data_d;
  logic                 fb_we_q, fb_we_d;

  logic [7:0] w_x0, w_x1, w_xl_raw, w_xh_raw, w_xl, w_xh;
  logic [6:0] w_y0, w_y1, w_yl_raw, w_yh_raw, w_yl, w_yh;
  logic       w_colour, w_start, w_irq_clr, w_empty;

  vga_fill_regs #(
    .BASE_ADDR (BASE_ADDR)
  ) u_regs (
    .clk_i       (CLK),
    .rst_i       (RESET),
    .bus_data_io (BUS_DATA),
    .bus_addr_i  (BUS_ADDR),
    .bus_we_i    (BUS_WE),
    .busy_i      (BUSY),
    .done_irq_i  (done_irq_q),
    .x0_o        (w_x0),
    .y0_o        (w_y0),
    .x1_o        (w_x1),
    .y1_o        (w_y1),
    .colour_o    (w_colour),
    .start_o     (w_start),
    .irq_clr_o   (w_irq_clr)
  );

  // Corner registers are frozen while busy, so bounds can be derived live
  assign w_xl_raw = (w_x0 < w_x1) ? w_x0 : w_x1;
  assign w_xh_raw = (w_x0 < w_x1) ? w_x1 : w_x0;
  assign w_yl_raw = (w_y0 < w_y1) ? w_y0 : w_y1;
  assign w_yh_raw = (w_y0 < w_y1) ? w_y1 : w_y0;

`ifdef VGA_FILL_CLIP_EN
  assign w_xl    = w_xl_raw;
  assign w_yl    = w_yl_raw;
  assign w_xh    = (w_xh_raw > X_MAX) ? X_MAX : w_xh_raw;
  assign w_yh    = (w_yh_raw > Y_MAX) ? Y_MAX : w_yh_raw;
  assign w_empty = (w_xl_raw > X_MAX) || (w_yl_raw > Y_MAX);
`else
  logic w_unused_clip;
  assign w_unused_clip = ^{X_MAX, Y_MAX};
  assign w_xl    = w_xl_raw;
  assign w_yl    = w_yl_raw;
  assign w_xh    = w_xh_raw;
  assign w_yh    = w_yh_raw;
  assign w_empty = 1'b0;
`endif

  always_comb begin
    state_d    = state_q;
    xl_d       = xl_q;
    xh_d       = xh_q;
    yl_d       = yl_q;
    yh_d       = yh_q;
    cx_d       = cx_q;
    cy_d       = cy_q;
    done_irq_d = done_irq_q;
    fb_we_d    = 1'b0;
    fb_addr_d  = fb_addr_q;
    fb_data_d  = fb_data_q;

    if (w_irq_clr) begin
      done_irq_d = 1'b0;
    end

    case (state_q)
      IDLE: begin
        if (w_start) begin
          state_d    = SETUP;
          done_irq_d = 1'b0;
        end
      end
      SETUP: begin
        xl_d = w_xl;
        xh_d = w_xh;
        yl_d = w_yl;
        yh_d = w_yh;
        cx_d = w_xl;
        cy_d = w_yl;
        if (w_empty) begin
          state_d    = DONE;
          done_irq_d = 1'b1;
        end else begin
          state_d = FILL;
        end
      end
      FILL: begin
        // A direct CPU write owns the port this cycle; position is held
        if (!CPU_PIX_WE) begin
          fb_we_d   = 1'b1;
          fb_addr_d = {cy_q, cx_q};
          fb_data_d = w_colour;
          if (cx_q == xh_q) begin
            cx_d = xl_q;
            if (cy_q == yh_q) begin
              state_d    = DONE;
              done_irq_d = 1'b1;
            end else begin
              cy_d = cy_q + 7'd1;
            end
          end else begin
            cx_d = cx_q + 8'd1;
          end
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    if (CPU_PIX_WE) begin
      fb_we_d   = 1'b1;
      fb_addr_d = CPU_PIX_ADDR;
      fb_data_d = CPU_PIX_DATA;
    end
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state_q    <= IDLE;
      xl_q       <= 8'd0;
      xh_q       <= 8'd0;
      yl_q       <= 7'd0;
      yh_q       <= 7'd0;
      cx_q       <= 8'd0;
      cy_q       <= 7'd0;
      done_irq_q <= 1'b0;
      fb_addr_q  <= '0;
      fb_data_q  <= 1'b0;
      fb_we_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      xl_q       <= xl_d;
      xh_q       <= xh_d;
      yl_q       <= yl_d;
      yh_q       <= yh_d;
      cx_q       <= cx_d;
      cy_q       <= cy_d;
      done_irq_q <= done_irq_d;
      fb_addr_q  <= fb_addr_d;
      fb_data_q  <= fb_data_d;
      fb_we_q    <= fb_we_d;
    end
  end

  assign BUSY     = (state_q != IDLE);
  assign DONE_IRQ = done_irq_q;
  assign FB_ADDR  = fb_addr_q;
  assign FB_DATA  = fb_data_q;
  assign FB_WE    = fb_we_q;

endmodule

`default_nettype wire

// File: tb/tb_vga_fill_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_vga_fill_ctrl
// Purpose  : Self-checking bench for vga_fill_ctrl against a pixel-list model
// Revision : 1.0 - initial release
// ============================================================================

module tb_vga_fill_ctrl;

  localparam logic [7:0] BASE = 8'hC0;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  wire  [7:0]  bus_data;
  logic        drv_en = 1'b0;
  logic [7:0]  drv_val = 8'h00;
  logic [7:0]  bus_addr = 8'h00;
  logic        bus_we = 1'b0;
  logic [14:0] cpu_addr = 15'h0;
  logic        cpu_data = 1'b0;
  logic        cpu_we = 1'b0;
  logic [14:0] fb_addr;
  logic        fb_data, fb_we, busy, done_irq;

  int n_total = 0;
  int n_bad   = 0;

  int          cyc = 0;
  int          busy_cnt = 0;
  int          first_cyc = -1;
  int          start_cyc = 0;
  logic        cpu_seen = 1'b0;
  logic [14:0] cpu_seen_addr = 15'h0;
  logic        cpu_seen_data = 1'b0;
  logic [15:0] eng_q[$];
  logic [15:0] exp_q[$];

  assign bus_data = drv_en ? drv_val : 8'hzz;

  always #5 clk = ~clk;

  vga_fill_ctrl dut (
    .CLK          (clk),
    .RESET        (rst),
    .BUS_DATA     (bus_data),
    .BUS_ADDR     (bus_addr),
    .BUS_WE       (bus_we),
    .CPU_PIX_ADDR (cpu_addr),
    .CPU_PIX_DATA (cpu_data),
    .CPU_PIX_WE   (cpu_we),
    .FB_ADDR      (fb_addr),
    .FB_DATA      (fb_data),
    .FB_WE        (fb_we),
    .BUSY         (busy),
    .DONE_IRQ     (done_irq)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Remember what the bench itself requested so the port owner is known
  always @(posedge clk) begin
    cyc           <= cyc + 1;
    cpu_seen      <= cpu_we;
    cpu_seen_addr <= cpu_addr;
    cpu_seen_data <= cpu_data;
  end

  always @(negedge clk) begin
    if (busy) busy_cnt++;
    if (fb_we && first_cyc < 0) first_cyc = cyc;
    if (cpu_seen && !rst) begin
      check("cpu_we", fb_we, 1);
      check("cpu_addr", fb_addr, cpu_seen_addr);
      check("cpu_data", fb_data, cpu_seen_data);
    end else if (fb_we) begin
      eng_q.push_back({fb_addr, fb_data});
    end
  end

  task automatic bus_write(input logic [7:0] a, input logic [7:0] d);
    @(posedge clk); #1;
    bus_addr = a; bus_we = 1'b1; drv_en = 1'b1; drv_val = d;
    @(posedge clk); #1;
    bus_addr = 8'h00; bus_we = 1'b0; drv_en = 1'b0;
  endtask

  task automatic bus_read(input logic [7:0] a, output logic [7:0] d);
    @(posedge clk); #1;
    bus_addr = a; bus_we = 1'b0;
    @(posedge clk); #1;
    bus_addr = 8'h00;
    d = bus_data;
  endtask

  // Expected engine pixels in raster order, straight from the rectangle rules
  task automatic build_exp(input int x0, input int y0, input int x1, input int y1, input bit col);
    int xl, xh, yl, yh;
    xl = (x0 < x1) ? x0 : x1;
    xh = (x0 < x1) ? x1 : x0;
    yl = (y0 < y1) ? y0 : y1;
    yh = (y0 < y1) ? y1 : y0;
    exp_q.delete();
`ifdef VGA_FILL_CLIP_EN
    if (xl > 159 || yl > 119) return;
    if (xh > 159) xh = 159;
    if (yh > 119) yh = 119;
`endif
    for (int y = yl; y <= yh; y++)
      for (int x = xl; x <= xh; x++)
        exp_q.push_back({y[6:0], x[7:0], col});
  endtask

  // mode: 0 plain, 1 one CPU stall, 2 two CPU writes to 0x1234,
  //       3 random CPU traffic, 4 register/START writes while busy
  task automatic do_fill(input string tag, input int x0, input int y0, input int x1,
                         input int y1, input bit col, input int mode, input bit with_clr);
    int k;
    int stalls;
    logic [7:0] ctrl;
    logic [7:0] rd;
    build_exp(x0, y0, x1, y1, col);
    bus_write(BASE + 8'd0, x0[7:0]);
    bus_write(BASE + 8'd1, y0[7:0]);
    bus_write(BASE + 8'd2, x1[7:0]);
    bus_write(BASE + 8'd3, y1[7:0]);
    ctrl = {5'b0, with_clr, 1'b1, col};
    eng_q.delete();
    busy_cnt  = 0;
    first_cyc = -1;
    bus_write(BASE + 8'd4, ctrl);
    start_cyc = cyc;
    check({tag, ":irq_at_start"}, done_irq, 0);
    check({tag, ":busy_at_setup"}, busy, 1);
    if (mode == 4) begin
      bus_write(BASE + 8'd0, 8'd99);
      bus_write(BASE + 8'd4, 8'h02);
    end
    k = 0;
    while (busy && k < 4000) begin
      @(posedge clk); #1;
      cpu_we   = (mode == 1 && k == 0) || (mode == 2 && k < 2) ||
                 (mode == 3 && $urandom_range(0, 3) == 0);
      cpu_addr = (mode == 2) ? 15'h1234 : 15'($urandom);
      cpu_data = (mode == 2) ? 1'b1 : 1'($urandom);
      k++;
    end
    check({tag, ":timeout"}, busy, 0);
    cpu_we = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check({tag, ":count"}, eng_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < eng_q.size(); i++)
      check($sformatf("%s:pix%0d", tag, i), eng_q[i], exp_q[i]);
    check({tag, ":irq"}, done_irq, 1);
    if (exp_q.size() > 0 && mode != 3)
      check({tag, ":latency"}, first_cyc - start_cyc, 2);
    if (mode != 3) begin
      stalls = (mode == 1) ? 1 : (mode == 2) ? 2 : 0;
      check({tag, ":busy_len"}, busy_cnt, (exp_q.size() == 0) ? 2 : exp_q.size() + stalls + 2);
    end
    bus_read(BASE + 8'd0, rd); check({tag, ":rd_x0"}, rd, x0[7:0]);
    bus_read(BASE + 8'd1, rd); check({tag, ":rd_y0"}, rd, {1'b0, y0[6:0]});
    bus_read(BASE + 8'd2, rd); check({tag, ":rd_x1"}, rd, x1[7:0]);
    bus_read(BASE + 8'd3, rd); check({tag, ":rd_y1"}, rd, {1'b0, y1[6:0]});
    bus_read(BASE + 8'd4, rd); check({tag, ":rd_ctrl"}, rd, {2'b01, 5'b0, col});
  endtask

  initial begin
    logic [7:0] rd;
    int x0, y0, x1, y1;

    repeat (3) @(posedge clk);
    #1;
    check("rst_fb_we", fb_we, 0);
    check("rst_fb_addr", fb_addr, 0);
    check("rst_fb_data", fb_data, 0);
    check("rst_busy", busy, 0);
    check("rst_irq", done_irq, 0);
    rst = 1'b0;
    for (int i = 0; i < 5; i++) begin
      bus_read(BASE + 8'(i), rd);
      check($sformatf("rst_reg%0d", i), rd, 0);
    end

    do_fill("rect", 2, 3, 4, 4, 1'b1, 0, 1'b0);
    bus_write(BASE + 8'd4, 8'h05);
    #1 check("irq_clr", done_irq, 0);
    do_fill("swap", 10, 5, 8, 5, 1'b0, 0, 1'b0);
    do_fill("clr_start", 1, 1, 1, 1, 1'b1, 0, 1'b1);
    do_fill("arb", 0, 0, 3, 0, 1'b1, 2, 1'b0);
    do_fill("last_pix", 7, 7, 7, 7, 1'b1, 1, 1'b0);
    do_fill("busy_prot", 0, 0, 9, 1, 1'b1, 4, 1'b0);
    repeat (5) @(posedge clk);
    #1 check("busy_prot_idle", busy, 0);
    do_fill("edge", 253, 126, 255, 127, 1'b1, 0, 1'b0);
    do_fill("clip_a", 150, 119, 200, 119, 1'b1, 0, 1'b0);
    do_fill("clip_b", 170, 119, 170, 119, 1'b0, 0, 1'b0);

    for (int r = 0; r < 6; r++) begin
      x0 = $urandom_range(0, 255);
      y0 = $urandom_range(0, 127);
      x1 = x0 + $urandom_range(0, 8) - 4;
      y1 = y0 + $urandom_range(0, 4) - 2;
      if (x1 < 0) x1 = 0;
      if (x1 > 255) x1 = 255;
      if (y1 < 0) y1 = 0;
      if (y1 > 127) y1 = 127;
      do_fill($sformatf("rand%0d", r), x0, y0, x1, y1, 1'($urandom), 3, 1'b0);
    end

    // Abort a long fill with an asynchronous reset between clock edges
    bus_write(BASE + 8'd0, 8'd0);
    bus_write(BASE + 8'd1, 8'd0);
    bus_write(BASE + 8'd2, 8'd99);
    bus_write(BASE + 8'd3, 8'd3);
    bus_write(BASE + 8'd4, 8'h03);
    repeat (20) @(posedge clk);
    #3 rst = 1'b1;
    #1;
    check("mid_rst_fb_we", fb_we, 0);
    check("mid_rst_fb_addr", fb_addr, 0);
    check("mid_rst_fb_data", fb_data, 0);
    check("mid_rst_busy", busy, 0);
    check("mid_rst_irq", done_irq, 0);
    @(posedge clk); #1;
    rst = 1'b0;
    eng_q.delete();
    repeat (10) @(posedge clk);
    #1;
    check("mid_rst_no_writes", eng_q.size(), 0);
    check("mid_rst_idle", busy, 0);
    for (int i = 0; i < 5; i++) begin
      bus_read(BASE + 8'(i), rd);
      check($sformatf("mid_rst_reg%0d", i), rd, 0);
    end

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/vga_fill_ctrl.md
Name: vga_fill_ctrl

Overview:
- Hardware rectangle-fill engine and write-port arbiter for the 160x120 1-bpp frame buffer port A.
- The processor programs a rectangle and a colour through bus registers and issues a start command. The block then walks every pixel and drives frame buffer write cycles.
- Direct processor pixel writes, coming from the VGA driver register path, share the same port and always take priority over the engine.

Parameters:
- BaseAddr, 8'hC0, bus address of register 0; the block decodes BaseAddr..BaseAddr+4.
- XMax, 159, last visible column.
- YMax, 119, last visible row.

Ports:
- CLK  in  1  system clock
- RESET  in  1  asynchronous, active-high reset
- BUS_DATA  inout  8  shared data bus; driven only on register reads
- BUS_ADDR  in  8  bus address
- BUS_WE  in  1  bus write strobe
- CPU_PIX_ADDR  in  15  direct pixel address {y[6:0],x[7:0]}
- CPU_PIX_DATA  in  1  direct pixel colour
- CPU_PIX_WE  in  1  direct pixel write request
- FB_ADDR  out  15  frame buffer port A address
- FB_DATA  out  1  frame buffer port A write data
- FB_WE  out  1  frame buffer port A write enable
- BUSY  out  1  fill in progress
- DONE_IRQ  out  1  sticky fill-complete flag

Behaviour:
- Reset (asynchronous): all registers 0, state IDLE, FB_ADDR=0, FB_DATA=0, FB_WE=0, BUSY=0, DONE_IRQ=0, BUS_DATA released (Z).
- Register map, offsets from BaseAddr:
  - 0: X0
  - 1: Y0[6:0]
  - 2: X1
  - 3: Y1[6:0]
  - 4 write: bit0 colour, bit1 START (pulse, not stored), bit2 IRQ_CLR (pulse).
  - 4 read: {BUSY, DONE_IRQ, 5'b0, colour}.
- Writes to offsets 0-3 and colour are ignored while BUSY. START while BUSY is ignored. IRQ_CLR is always honoured.
- Bus reads: the data and the drive-enable are both registered. BUS_DATA is driven the cycle after a matching address with BUS_WE=0. Otherwise high-Z.
- Port arbitration is combinational into the output registers; FB_* are registered, giving one-cycle latency.
  - CPU_PIX_WE=1: next cycle FB_WE=1, FB_ADDR=CPU_PIX_ADDR, FB_DATA=CPU_PIX_DATA. The engine stalls with its position held.
  - Otherwise, in FILL: next cycle FB_WE=1 with the engine address and colour.
  - Otherwise FB_WE=0.
- State machine:
  - IDLE -> SETUP on START (write to offset 4 with bit1=1). DONE_IRQ clears at the same edge.
  - SETUP (1 cycle):
    - xl=min(X0,X1), xh=max(X0,X1), likewise yl/yh (swap rule).
    - Load cx=xl, cy=yl.
    - BUSY=1 from this cycle.
  - FILL, each non-stalled cycle:
    - Issue pixel (cx,cy).
    - If cx==xh: cx=xl, and cy=cy+1 unless cy==yh.
    - Else cx=cx+1.
    - On the issue with cx==xh and cy==yh -> DONE.
  - DONE (1 cycle): DONE_IRQ=1 (sticky until IRQ_CLR or the next START). BUSY=0 at exit. -> IDLE.
- Latency and cycle count:
  - START accepted at edge N; first engine FB_WE visible after edge N+2.
  - FILL lasts (xh-xl+1)*(yh-yl+1) + stall cycles.
- Arithmetic: cx is 8-bit and cy 7-bit. Comparisons use equality with the bounds, so there is no wrap even at x=255 or y=127.
- Degenerate rectangles: X0==X1 and Y0==Y1 writes exactly one pixel.
- Simultaneous events:
  - IRQ_CLR and START in the same write: START wins and DONE_IRQ=0.
  - CPU_PIX_WE on the last engine pixel: the last pixel slips one cycle; DONE follows its issue.
- RESET mid-fill: immediate abort to IDLE, all outputs at reset values, and no further writes.

Optional Feature:
- Macro: VGA_FILL_CLIP_EN.
- Defined: SETUP clamps xl/xh to XMax and yl/yh to YMax. If the resulting xl>XMax or yl>YMax, the engine goes SETUP->DONE and writes no pixels.
- Undefined: coordinates are used raw, so off-screen addresses may be written; there is no clamping logic.

Decomposition:
- Shared package vga_pkg holds:
  - the FILL_* register offset constants
  - CTRL bit positions (CTRL_COLOUR=0, CTRL_START=1, CTRL_IRQCLR=2)
  - FB_ADDR_W=15 and the XMax/YMax defaults
  - the state encoding typedef {IDLE, SETUP, FILL, DONE}
- One natural sub-module, vga_fill_regs: the bus register bank, tristate driver and START/IRQ_CLR pulse generation.
- Sequencer and arbiter stay in the top module.

Test Plan:
- Rectangle fill: X0=2, Y0=3, X1=4, Y1=4, colour=1, START -> exactly 6 FB_WE pulses at (2,3)(3,3)(4,3)(2,4)(3,4)(4,4), FB_DATA=1. First pulse 2 cycles after START. Then DONE_IRQ=1 and BUSY=0.
- Swapped corners: X0=10, X1=8, Y0=Y1=5 -> addresses {5,8},{5,9},{5,10}; 3 writes.
- Arbitration: during fill of (0,0)-(3,0), assert CPU_PIX_WE with addr 0x1234 for 2 cycles -> those 2 cycles write 0x1234; the engine resumes without skipping or duplicating and still totals 4 writes.
- Busy protection: while filling, write X0=99 and START -> no effect on the current fill; a readback of offset 0 returns the original X0.
- Reset mid-fill: RESET pulsed asynchronously during FILL -> FB_WE=0 immediately, BUSY=0, all registers read 0.
- Clip (VGA_FILL_CLIP_EN): X0=150, X1=200, Y0=Y1=119 -> 10 writes, x=150..159. With X0=X1=170 -> 0 writes and DONE_IRQ=1.
